// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - registered ALU with iterative MUL/DIVU/REMU behind start/busy/done
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       ALU_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_out,
    output logic             zero,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    // a: multiplicand in MUL, quotient/dividend in DIV; b: multiplier or divisor;
    // acc: product accumulator in MUL, partial remainder in DIV
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff, res_single, acc_step, quo_new, rem_new, iter_res;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             ovf_single, rem_ge, last_step, is_div_op;

    // Single-cycle result and overflow straight from the live inputs
    always_comb begin
        sum        = operand1 + operand2;
        diff       = operand1 - operand2;
        res_single = operand1;
        ovf_single = 1'b0;
        case (ALU_control)
            OP_AND:  res_single = operand1 & operand2;
            OP_OR:   res_single = operand1 | operand2;
            OP_ADD: begin
                res_single = sum;
                ovf_single = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                             (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                res_single = diff;
                ovf_single = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                             (diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SLT:  res_single = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_DIVU: res_single = '1;        // divide by zero: all-ones quotient
            OP_REMU: res_single = operand1;  // divide by zero: remainder is the dividend
            default: res_single = operand1;
        endcase
    end

    // One shift-add multiply step and one restoring divide step per cycle
    always_comb begin
        acc_step  = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_sh    = {acc_q, a_q[WIDTH-1]};
        rem_sub   = rem_sh - {1'b0, b_q};
        rem_ge    = !rem_sub[WIDTH];
        rem_new   = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_new   = {a_q[WIDTH-2:0], rem_ge};
        iter_res  = (op_q == OP_REMU) ? rem_new : quo_new;
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
        is_div_op = (ALU_control == OP_DIVU) || (ALU_control == OP_REMU);
    end

    // Control FSM: accept in IDLE, iterate in MUL/DIV, pulse done in DONE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = ALU_control;
                    a_d   = operand1;
                    b_d   = operand2;
                    acc_d = '0;
                    cnt_d = '0;
                    if (ALU_control == OP_MUL) begin
                        state_d = S_MUL;
                        busy_d  = 1'b1;
                    end else if (is_div_op && (operand2 != '0)) begin
                        state_d = S_DIV;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        out_d   = res_single;
                        zero_d  = (res_single == '0);
                        ovf_d   = ovf_single;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = acc_step;
                    zero_d  = (acc_step == '0);
                    ovf_d   = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = rem_new;
                a_d   = quo_new;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = iter_res;
                    zero_d  = (iter_res == '0);
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ALU_out  = out_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] operand1, operand2;
    logic [3:0]  ALU_control;
    logic        busy, done, zero, overflow;
    logic [31:0] ALU_out;

    int checks = 0;
    int failures = 0;

    multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start),
        .operand1(operand1), .operand2(operand2), .ALU_control(ALU_control),
        .busy(busy), .done(done), .ALU_out(ALU_out), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_ovf;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model from the arithmetic definitions
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic v, output int lat);
        longint s;
        logic [63:0] p;
        v   = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
                lat = 33;
            end
            4'b1001: begin
                r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                lat = (b == 0) ? 1 : 33;
            end
            4'b1010: begin
                r = (b == 0) ? a : a % b;
                lat = (b == 0) ? 1 : 33;
            end
            default: r = a;
        endcase
    endtask

    // Issue one op from idle, scramble inputs after acceptance, wait for done
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic ez, input logic ev,
                         input int elat, input string nm);
        int lat;
        int busy_err;
        @(negedge clk);
        ALU_control = op; operand1 = a; operand2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; operand1 = $urandom; operand2 = $urandom; ALU_control = 4'b0010;
        lat = 1;
        busy_err = 0;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_err++;
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, elat);
        check({nm, " busy"}, busy_err, 0);
        check({nm, " out"}, ALU_out, eo);
        check({nm, " zero"}, {31'd0, zero}, {31'd0, ez});
        check({nm, " ovf"}, {31'd0, overflow}, {31'd0, ev});
        check({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0]  ops[10];
        logic [31:0] r, ra, rb;
        logic        v;
        int          lat, ndone, dcyc;
        logic [31:0] dout;

        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1111};

        vecs.push_back('{4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1, "add_ovf"});
        vecs.push_back('{4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1, "sub_zero"});
        vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, "slt_neg"});
        vecs.push_back('{4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1, "slt_pos"});
        vecs.push_back('{4'b1111, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, "pass"});
        vecs.push_back('{4'b1000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 1'b0, 33, "mul"});
        vecs.push_back('{4'b1001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, "divu"});
        vecs.push_back('{4'b1010, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33, "remu"});
        vecs.push_back('{4'b1001, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, "divu_by0"});
        vecs.push_back('{4'b1010, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1, "remu_by0"});
        vecs.push_back('{4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, "sub_ovf"});
        vecs.push_back('{4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1, 1'b0, 1, "and_zero"});
        vecs.push_back('{4'b1010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 33, "remu_big"});

        reset = 1'b1; start = 1'b0; operand1 = '0; operand2 = '0; ALU_control = '0;
        @(negedge clk); @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset out", ALU_out, 32'd0);
        check("reset zero_ovf", {30'd0, zero, overflow}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out,
                  vecs[i].exp_zero, vecs[i].exp_ovf, vecs[i].exp_lat, vecs[i].name);

        // Reset for two cycles in the middle of a MUL
        @(negedge clk);
        ALU_control = 4'b1000; operand1 = 32'd7; operand2 = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("midmul busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        check("rst_mid out", ALU_out, 32'd0);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_mid no_done", ndone, 0);
        do_op(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, "after_reset");

        // Start pulsed during busy is ignored; exactly one done at cycle 33
        @(negedge clk);
        ALU_control = 4'b1000; operand1 = 32'h0001_0003; operand2 = 32'h0002_0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; dcyc = 0; dout = '0;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin ndone++; dcyc = c; dout = ALU_out; end
            if (c == 3) begin start = 1'b1; ALU_control = 4'b0010; operand1 = 32'd1; operand2 = 32'd1; end
            if (c == 4) start = 1'b0;
            @(negedge clk);
        end
        check("busy_start ndone", ndone, 1);
        check("busy_start cycle", dcyc, 33);
        check("busy_start out", dout, 32'h000B_000F);

        // Start held high with ADDs: one done every 2 cycles
        @(negedge clk);
        ALU_control = 4'b0010; start = 1'b1;
        operand1 = 32'd1; operand2 = 32'd0;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) ndone++;
            check($sformatf("held done%0d", k), {31'd0, done}, {31'd0, (k % 2) == 1});
            if (k % 2 == 1)
                check($sformatf("held out%0d", k), ALU_out, 32'(4 * (k - 1) + 1));
            operand1 = 32'(3 * k + 1); operand2 = 32'(k);
        end
        start = 1'b0;
        check("held ndone", ndone, 5);
        repeat (3) @(negedge clk);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = ops[$urandom_range(0, 9)];
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            model(op, ra, rb, r, v, lat);
            do_op(op, ra, rb, r, (r == 32'd0), v, lat, $sformatf("rand%0d op%0h", i, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
